// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and FSM state encoding for the buffered UART transmitter.
package uart_tx_fifo_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 868;
    localparam int unsigned UART_FIFO_DEPTH   = 16;
    localparam int unsigned UART_DATA_BITS    = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock circular FIFO with registered status; reused by the UART RX path later.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_d;
    logic             push_ok;
    logic             pop_ok;

    // Full/empty are evaluated before the edge, so a push while full is dropped even with a pop.
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign rd_data_c = mem[rd_ptr];

    always_comb begin
        count_d = count;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
            full  <= (count_d == CW'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a baud-timed serializer.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = UART_FIFO_DEPTH
) (
    input  logic                          CLK100MHZ,
    input  logic                          CPU_RESETN,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          clr_overflow,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_busy,
    output logic                          overflow,
    output logic                          uart_rxd_out
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        line_q, line_d;
    logic        busy_q;
    logic        ovf_q;
    logic        pop_c;
    logic        baud_last_c;
    logic [7:0]  head_c;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK100MHZ),
        .rst_n     (CPU_RESETN),
        .push      (wr_en),
        .wr_data   (wr_data),
        .pop       (pop_c),
        .rd_data_c (head_c),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign baud_last_c = (baud_q == BAUD_LAST);

    // Next-state and next-line logic; line is registered so the pin never glitches.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        line_d  = line_q;
        pop_c   = 1'b0;
        case (state_q)
            TX_IDLE: begin
                line_d = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = head_c;
                    line_d  = 1'b0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (baud_last_c) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    line_d  = shift_q[0];
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            TX_DATA: begin
                if (baud_last_c) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        line_d  = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        line_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            TX_STOP: begin
                if (baud_last_c) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shift_d = head_c;
                        line_d  = 1'b0;
                        state_d = TX_START;
                    end else begin
                        line_d  = 1'b1;
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                line_d  = 1'b1;
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            line_q  <= line_d;
            busy_q  <= (state_d != TX_IDLE);
        end
    end

    // Sticky overflow: a dropped write beats a same-edge clear.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            ovf_q <= 1'b0;
        end else if (wr_en && fifo_full) begin
            ovf_q <= 1'b1;
        end else if (clr_overflow) begin
            ovf_q <= 1'b0;
        end
    end

    assign uart_rxd_out = line_q;
    assign tx_busy      = busy_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Cycle-by-cycle check of uart_tx_fifo against a frame-level queue model.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       CLK100MHZ;
    logic       CPU_RESETN;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_overflow;
    logic       fifo_full;
    logic       fifo_empty;
    logic [2:0] fifo_count;
    logic       tx_busy;
    logic       overflow;
    logic       uart_rxd_out;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_q[$];
    logic [7:0] m_cur;
    int         m_left;
    bit         m_busy;
    bit         m_ovf;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK100MHZ    (CLK100MHZ),
        .CPU_RESETN   (CPU_RESETN),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .clr_overflow (clr_overflow),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .tx_busy      (tx_busy),
        .overflow     (overflow),
        .uart_rxd_out (uart_rxd_out)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Line level implied by the position inside the current 8N1 frame.
    function automatic logic exp_line();
        int pos;
        int b;
        if (!m_busy) return 1'b1;
        pos = FRAME - m_left;
        b   = pos / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    task automatic check_all(input string where);
        chk({where, " line"},  32'(uart_rxd_out), 32'(exp_line()));
        chk({where, " count"}, 32'(fifo_count),   32'(m_q.size()));
        chk({where, " full"},  32'(fifo_full),    32'(m_q.size() == DEPTH));
        chk({where, " empty"}, 32'(fifo_empty),   32'(m_q.size() == 0));
        chk({where, " busy"},  32'(tx_busy),      32'(m_busy));
        chk({where, " ovf"},   32'(overflow),     32'(m_ovf));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur  = 8'h00;
        m_left = 0;
        m_busy = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic tick(input bit w, input logic [7:0] d, input bit c, input string where);
        bit full_pre;
        bit empty_pre;
        bit pop;
        bit push;
        wr_en        = w;
        wr_data      = d;
        clr_overflow = c;
        @(posedge CLK100MHZ);
        full_pre  = (m_q.size() == DEPTH);
        empty_pre = (m_q.size() == 0);
        pop  = !empty_pre && (!m_busy || m_left == 1);
        push = w && !full_pre;
        if (w && full_pre) m_ovf = 1'b1;
        else if (c)        m_ovf = 1'b0;
        if (pop) begin
            m_cur  = m_q.pop_front();
            m_left = FRAME;
            m_busy = 1'b1;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) m_busy = 1'b0;
        end
        if (push) m_q.push_back(d);
        #1;
        check_all(where);
    endtask

    task automatic drain(input string where);
        for (int i = 0; i < 1000 && (m_busy || m_q.size() != 0); i++) tick(1'b0, 8'h00, 1'b0, where);
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, where);
    endtask

    initial begin
        CPU_RESETN   = 1'b0;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        clr_overflow = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        #11;
        CPU_RESETN = 1'b1;

        for (int i = 0; i < 50; i++) tick(1'b0, 8'h00, 1'b0, "idle");

        tick(1'b1, 8'hA5, 1'b0, "a5_wr");
        for (int i = 0; i < 45; i++) tick(1'b0, 8'h00, 1'b0, "a5_frame");

        tick(1'b1, 8'h55, 1'b0, "b2b_wr0");
        tick(1'b1, 8'h0F, 1'b0, "b2b_wr1");
        drain("b2b");

        for (int i = 1; i <= 6; i++) tick(1'b1, 8'(i), 1'b0, "fill");
        tick(1'b0, 8'h00, 1'b1, "clr_ovf");
        tick(1'b1, 8'h77, 1'b1, "clr_vs_drop");
        drain("fill_drain");

        tick(1'b1, 8'hC3, 1'b0, "rst_wr0");
        tick(1'b1, 8'h3C, 1'b0, "rst_wr1");
        tick(1'b1, 8'h99, 1'b0, "rst_wr2");
        for (int i = 0; i < 12; i++) tick(1'b0, 8'h00, 1'b0, "pre_rst");
        #3;
        CPU_RESETN = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge CLK100MHZ);
        @(posedge CLK100MHZ);
        #3;
        CPU_RESETN = 1'b1;
        for (int i = 0; i < 60; i++) tick(1'b0, 8'h00, 1'b0, "post_rst");

        for (int i = 0; i < 1500; i++)
            tick(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 15) == 0), "rand");
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter, downstream of the CPU's memory-mapped I/O decode.
- CPU store instructions to the UART data address push bytes through a single-cycle write strobe.
- The block queues those bytes in a FIFO and serializes them onto the board TX pin (uart_rxd_out).
- Status outputs (full, empty, count, busy, overflow) are exposed so firmware can poll them via loads to the UART status address.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200 baud); legal range is 2 or more.
- FIFO_DEPTH, 16: number of byte entries; must be a power of two, 2 or more.

Ports:
- CLK100MHZ  input  1  system clock; all state changes on the rising edge.
- CPU_RESETN  input  1  asynchronous, active-low reset.
- wr_en  input  1  one-cycle write strobe from the mmio store decode.
- wr_data  input  8  byte to enqueue; sampled when wr_en=1.
- clr_overflow  input  1  one-cycle strobe that clears the overflow flag.
- fifo_full  output  1  high when count == FIFO_DEPTH.
- fifo_empty  output  1  high when count == 0.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued; excludes the byte currently being shifted out.
- tx_busy  output  1  high whenever the FSM is not in IDLE.
- overflow  output  1  sticky; set when a write is dropped.
- uart_rxd_out  output  1  serial TX line; idles high.

Behaviour:
- Clock and reset:
  - One clock, CLK100MHZ.
  - Reset is asynchronous, active-low, on CPU_RESETN. Assertion takes effect immediately; release is sampled on the clock edge.
- Reset values:
  - uart_rxd_out=1, fifo_count=0, fifo_empty=1, fifo_full=0, tx_busy=0, overflow=0.
  - FSM in IDLE; FIFO read and write pointers = 0; bit counter and baud counter = 0.
- FIFO:
  - Circular buffer with pointer wrap at FIFO_DEPTH.
  - Write accepted on an edge where wr_en=1 and fifo_full=0 before that edge. fifo_count increments at that edge.
  - Write with fifo_full=1 is dropped and overflow is set at that edge. This holds even if a pop occurs on the same edge; full is evaluated before the edge.
  - Simultaneous accepted write and pop leaves fifo_count unchanged; both pointers advance.
  - If clr_overflow and a dropped write occur on the same edge, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - The baud counter counts 0..CLKS_PER_BIT-1 in START, DATA and STOP; it resets to 0 on each state entry and on each bit advance.
  - IDLE: line=1. If fifo_empty=0, the next edge pops the head byte into the shift register, sets line=0 and enters START.
  - START: hold line=0 for CLKS_PER_BIT cycles, then drive bit 0 and enter DATA with bit index 0.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7's last cycle, set line=1 and enter STOP.
  - STOP: hold line=1 for CLKS_PER_BIT cycles. On the final cycle:
    - if the FIFO is non-empty, pop, set line=0 and enter START (back-to-back frames, no idle gap);
    - otherwise enter IDLE.
- Timing:
  - uart_rxd_out is registered and must be glitch-free.
  - Latency: write accepted at edge E into an empty idle block, then line falls at edge E+1.
  - Each frame is exactly 10*CLKS_PER_BIT cycles.
- Reset mid-frame: line returns to 1 immediately and FIFO contents are discarded. A partial frame on the wire is acceptable.
- wr_data is ignored when wr_en=0.

Decomposition:
- constant_defs.v gains:
  - `UART_CLKS_PER_BIT (868);
  - `UART_FIFO_DEPTH (16);
  - 2-bit FSM state encodings `TX_IDLE, `TX_START, `TX_DATA, `TX_STOP.
- One sub-module, sync_fifo:
  - Parameterized width and depth, with push, pop, full, empty and count.
  - Reusable later for the UART RX path.
- The top holds the FSM, baud counter and shift register.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 for simulation):
- Reset then idle 50 cycles -> uart_rxd_out=1, fifo_empty=1, tx_busy=0, fifo_count=0.
- Single write 8'hA5 at edge E -> line low at E+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high 4 cycles. tx_busy falls at E+41.
- Write 8'h55, 8'h0F on consecutive cycles -> two frames with no idle gap between stop bit and next start bit; fifo_count sequence 1, then 1 (pop+push on the same edge), then 0.
- Six consecutive writes 0x01..0x06 -> first popped immediately, next four fill the FIFO (fifo_full=1), sixth is dropped and overflow=1; wire carries 0x01..0x05 only.
- clr_overflow pulse after the previous test -> overflow=0. Same-edge clr_overflow with a dropped write -> overflow stays 1.
- Assert CPU_RESETN=0 mid-DATA of a frame with 2 bytes queued -> line=1 immediately, fifo_count=0, tx_busy=0. After release, no further frames are sent.
